// File: rtl/rca_nibble_scheduler_pkg.sv
// Shared types and helpers for the nibble-serial adder scheduler.
package rca_sched_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int NIBBLE  = 4;
    localparam int MAX_REQ = 32;

    // Walks from farthest to nearest so the first valid after 'last' wins.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int nreq, input int last);
        int pick;
        int idx;
        pick = 0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (last + k) % nreq;
                if (valid[idx]) pick = idx;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/rca_nibble_slice.sv
// Combinational 4-bit ripple-carry adder slice; the resource shared by all requesters.
module rca_nibble_slice
    import rca_sched_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout
);
    logic [NIBBLE:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE];
endmodule

// File: rtl/rca_nibble_scheduler.sv
// Round-robin scheduler sharing one nibble adder slice; adds run LSB nibble first.
module rca_nibble_scheduler
    import rca_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);
    localparam int NIB  = WIDTH / NIBBLE;
    localparam int NIBW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int IDW  = $clog2(NREQ);

    if (WIDTH % NIBBLE != 0 || WIDTH < NIBBLE) begin : g_bad_width
        $fatal(1, "rca_nibble_scheduler: WIDTH must be a positive multiple of 4");
    end
    if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
        $fatal(1, "rca_nibble_scheduler: NREQ must be in 2..32");
    end

    state_t            state;
    logic [WIDTH-1:0]  op_a, op_b, sum_reg;
    logic              carry_reg;
    logic [NIBW-1:0]   nib_idx;
    logic [IDW-1:0]    last_grant, id_reg, grant;
    logic [NIBBLE-1:0] sl_a, sl_b, sl_s;
    logic              sl_cout;
    int                nib_base;

    assign grant = IDW'(rr_pick(MAX_REQ'(req_valid), NREQ, int'(last_grant)));

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && |req_valid) req_ready[grant] = 1'b1;
    end

    assign nib_base = int'(nib_idx) * NIBBLE;
    assign sl_a     = op_a[nib_base +: NIBBLE];
    assign sl_b     = op_b[nib_base +: NIBBLE];

    rca_nibble_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_reg),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            nib_idx    <= '0;
            id_reg     <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|(req_valid & req_ready)) begin
                    op_a       <= req_a[int'(grant) * WIDTH +: WIDTH];
                    op_b       <= req_b[int'(grant) * WIDTH +: WIDTH];
                    carry_reg  <= req_cin[grant];
                    id_reg     <= grant;
                    last_grant <= grant;
                    nib_idx    <= '0;
                    state      <= ADD;
                end
                ADD: begin
                    sum_reg[nib_base +: NIBBLE] <= sl_s;
                    carry_reg                   <= sl_cout;
                    nib_idx                     <= nib_idx + 1'b1;
                    if (nib_idx == NIBW'(NIB - 1)) begin
                        nib_idx   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result fields come straight from the working registers; they only change outside DONE.
    assign rsp_sum  = sum_reg;
    assign rsp_cout = carry_reg;
    assign rsp_id   = id_reg;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_rca_nibble_scheduler.sv
// Randomized and directed checks of rca_nibble_scheduler against a transaction-level model.
module tb_rca_nibble_scheduler;
    localparam int NREQ  = 2;
    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_cin = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        busy;

    int nerr = 0;
    int nchk = 0;
    int last_srv = 1;

    always #5 clk = ~clk;

    rca_nibble_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester after the one served last.
    function automatic int model_pick(input logic [1:0] m);
        for (int k = 1; k <= NREQ; k++)
            if (m[(last_srv + k) % NREQ]) return (last_srv + k) % NREQ;
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_cin[i]        = c;
    endtask

    task automatic check_rsp(input string tag, input logic [16:0] full, input int g);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_sum"}, rsp_sum, full[15:0]);
        chk({tag, "_cout"}, rsp_cout, full[16]);
        chk({tag, "_id"}, rsp_id, g);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic txn(input logic [1:0] mask, input int hold, input bit early);
        int g;
        int lat;
        logic [16:0] full;
        g   = -1;
        lat = 0;
        req_valid = mask;
        while (g < 0 && lat < 50) begin
            @(negedge clk);
            if (req_ready != 0) g = req_ready[1] ? 1 : 0;
            lat++;
        end
        if (g < 0) begin
            chk("accept_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        chk("grant", g, model_pick(mask));
        chk("ready_onehot", $countones(req_ready), 1);
        full = 17'(req_a[g*16 +: 16]) + 17'(req_b[g*16 +: 16]) + 17'(req_cin[g]);
        last_srv = g;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        if (early) rsp_ready = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            chk("holdoff_ready", req_ready, 0);
            chk("busy_add", busy, 1);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, NIB);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                check_rsp("hold", full, g);
                @(posedge clk); #1;
            end
        end
        check_rsp("rsp", full, g);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        last_srv  = 1;

        set_op(0, 16'h00FF, 16'h0001, 1'b0); txn(2'b01, 0, 1'b0);
        set_op(0, 16'hFFFF, 16'h0001, 1'b0); txn(2'b01, 0, 1'b0);
        set_op(0, 16'hFFFF, 16'h0000, 1'b1); txn(2'b01, 0, 1'b1);
        set_op(0, 16'h0FFF, 16'h0000, 1'b1); txn(2'b01, 2, 1'b0);

        // Abort an add after two nibbles; nothing may come out of it.
        set_op(0, 16'hABCD, 16'h1111, 1'b0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        chk("abort_accept", busy, 1);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        last_srv = 1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_sum", rsp_sum, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_stale", rsp_valid, 0);
        end
        set_op(1, 16'h1234, 16'h1111, 1'b0); txn(2'b10, 0, 1'b0);

        set_op(0, 16'($urandom), 16'($urandom), 1'($urandom));
        set_op(1, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 0, 1'b0);
            chk("rr_order", last_srv, i % 2);
            set_op(last_srv, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        set_op(0, 16'h8001, 16'h7FFF, 1'b0); txn(2'b01, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            set_op(last_srv, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
